// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache, one 32-bit word per frame.
//   A hit is answered combinationally in the same cycle; a miss launches a
//   single-word fill from memory and keeps ihit low until the frame is valid.
//   Hit cycles and misses (fills started) are counted for performance debug.
//
// Ports
//   CLK       in   1   clock, all state updates on the rising edge
//   RST       in   1   synchronous, active-high reset
//   imemREN   in   1   datapath instruction read request
//   imemaddr  in  32   datapath fetch address (byte address, word aligned)
//   imemload  out 32   instruction word, valid only when ihit = 1
//   ihit      out  1   fetch satisfied this cycle
//   iREN      out  1   memory read request
//   iaddr     out 32   memory read address
//   iload     in  32   memory read data, valid when iwait = 0 and iREN = 1
//   iwait     in   1   memory busy, 0 means iload is valid this cycle
//   hit_cnt   out 32   count of hit cycles
//   miss_cnt  out 32   count of misses (fills started)
// -----------------------------------------------------------------------------
module icache_direct #(
    parameter int NSETS = 16,
    parameter int IDX_W = $clog2(NSETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // Frame index field of a byte address.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    // Tag field of a byte address.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:IDX_W+2];
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        miss_addr_r;
    logic [31:0]        hit_cnt_r;
    logic [31:0]        miss_cnt_r;

    logic [NSETS-1:0]   valid_r;
    logic [TAG_W-1:0]   tag_r  [NSETS];
    logic [31:0]        data_r [NSETS];

    logic [IDX_W-1:0]   lookup_idx_s;
    logic [TAG_W-1:0]   lookup_tag_s;
    logic [IDX_W-1:0]   fill_idx_s;
    logic               tag_match_s;
    logic               hit_s;
    logic               miss_s;
    logic               fill_s;

    assign lookup_idx_s = addr_idx(imemaddr);
    assign lookup_tag_s = addr_tag(imemaddr);
    assign fill_idx_s   = addr_idx(miss_addr_r);
    assign tag_match_s  = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s);

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;

    // Next-state logic and datapath/memory-side outputs.
    always_comb begin
        state_next_s = state_r;
        hit_s        = 1'b0;
        miss_s       = 1'b0;
        fill_s       = 1'b0;
        ihit         = 1'b0;
        imemload     = 32'h0000_0000;
        iREN         = 1'b0;
        iaddr        = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (imemREN && tag_match_s) begin
                    hit_s    = 1'b1;
                    ihit     = 1'b1;
                    imemload = data_r[lookup_idx_s];
                end else if (imemREN) begin
                    miss_s       = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                // Fill targets the latched miss address only, so the
                // datapath may move its fetch address without harm.
                iREN  = 1'b1;
                iaddr = miss_addr_r;
                if (!iwait) begin
                    fill_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Control state, latched miss address, valid bits and counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            miss_addr_r <= 32'h0000_0000;
            hit_cnt_r   <= 32'h0000_0000;
            miss_cnt_r  <= 32'h0000_0000;
            valid_r     <= {NSETS{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (hit_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (miss_s) begin
                miss_addr_r <= imemaddr;
                miss_cnt_r  <= miss_cnt_r + 32'd1;
            end
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are meaningless while the valid bit is 0,
    // so they carry no reset.
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            tag_r[fill_idx_s]  <= addr_tag(miss_addr_r);
            data_r[fill_idx_s] <= iload;
        end
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the pipelined datapath's instruction port and the memory controller.
- On the datapath side it accepts the fetch address and returns the instruction word with a hit strobe. That strobe is the datapath's PC/IF-ID advance enable.
- On a miss it runs a single-word fill from memory and holds `ihit` low until the line is valid.
- It also counts hits and misses for performance debug.

Parameters:
- `NSETS`, 16, number of frames. Must be a power of two, at least 2. One 32-bit word per frame.
- `IDX_W`, `$clog2(NSETS)`, index width (derived; not overridden).

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `RST`  in  1  synchronous, active-high reset
- `imemREN`  in  1  datapath instruction read request
- `imemaddr`  in  32  datapath fetch address (byte address, word aligned)
- `imemload`  out  32  instruction word; valid only when `ihit`=1
- `ihit`  out  1  fetch satisfied this cycle
- `iREN`  out  1  memory read request
- `iaddr`  out  32  memory read address
- `iload`  in  32  memory read data; valid when `iwait`=0 and `iREN`=1
- `iwait`  in  1  memory busy; 0 means `iload` is valid this cycle
- `hit_cnt`  out  32  count of hit cycles
- `miss_cnt`  out  32  count of misses (fills started)

Behaviour:
- Reset/clock: one clock, `CLK`. Reset `RST` is synchronous and active-high.
- Address split:
  - [1:0] byte offset, ignored.
  - [IDX_W+1:2] index.
  - [31:IDX_W+2] tag.
  - With `NSETS`=16: index = addr[5:2], tag = addr[31:6].
- Storage: per frame one valid bit, one tag, one 32-bit data word.
- Reset:
  - All valid bits cleared; tags and data are don't-care.
  - state = `IDLE`; `miss_addr` = 0; `hit_cnt` = `miss_cnt` = 0.
  - Outputs after reset: `ihit`=0, `iREN`=0, `iaddr`=0, `imemload`=0.
- FSM states: `IDLE`, `FETCH`.
- `IDLE`:
  - hit = `imemREN` & valid[idx] & (tag[idx] == addr tag).
  - On hit: `ihit`=1 and `imemload`=data[idx], both combinational, same cycle. `hit_cnt` increments. Zero added latency.
  - On miss (`imemREN`=1, not hit): `ihit`=0; `miss_addr` <= `imemaddr`; `miss_cnt` increments; next state `FETCH`.
  - `imemREN`=0: `ihit`=0, no state change, no counter change.
  - `iREN`=0 in `IDLE`.
- `FETCH`:
  - `iREN`=1 and `iaddr`=`miss_addr`, held stable for the whole state.
  - `ihit`=0 and `imemload`=0 for the whole state.
  - While `iwait`=1: stay in `FETCH`.
  - First cycle with `iwait`=0: write frame index(`miss_addr`) with valid=1, tag(`miss_addr`), data=`iload`. Next state `IDLE`.
  - No bypass of the fill data: the retried fetch hits in the following `IDLE` cycle.
- Miss penalty: `ihit` rises (W+2) cycles after the miss cycle, where W = number of `iwait`=1 cycles seen in `FETCH`.
- Fill completion does not depend on `imemREN` or `imemaddr`.
  - If `imemREN` drops or `imemaddr` changes during `FETCH`, the fill completes to `miss_addr`.
  - The new address is then looked up fresh in `IDLE`.
- A fill overwrites the frame unconditionally (eviction); there is no write path and no dirty state.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0 with no flag.
- Reset mid-`FETCH`: at the reset edge, state returns to `IDLE`, `iREN` drops and all frames invalidate. Any pending memory data is ignored.
- Simultaneous miss and reset: reset wins; no counter increment.

Test Plan:
1. Cold miss: `RST` 1 cycle, then `imemREN`=1, `imemaddr`=0x00000000, memory `iwait`=1 for 2 cycles then `iload`=0x20010005.
   - Required: `iREN`=1 with `iaddr`=0x0 for 3 cycles.
   - `ihit`=1 with `imemload`=0x20010005 on the 4th cycle after the miss cycle.
   - `miss_cnt`=1, `hit_cnt`=1.
2. Warm hit: repeat fetch of 0x0 for 5 cycles → `ihit`=1 every cycle, `iREN`=0, `hit_cnt` increments by 5.
3. Conflict eviction: fill 0x00 (data 0xAAAA0000), then fetch 0x40 (data 0xBBBB0000, same index 0, tag 1), then fetch 0x00 again.
   - Required: both later fetches miss; `miss_cnt`=3.
   - Final `imemload`=0xAAAA0000.
4. Zero-wait fill: `iwait`=0 throughout, fetch 0x104 → `FETCH` lasts exactly 1 cycle; `ihit` in the cycle 2 after the miss cycle.
5. Address change during fill: miss on 0x08, then switch `imemaddr` to 0x0C mid-`FETCH`.
   - Required: `iaddr` stays 0x08; frame 2 gets the fill.
   - 0x0C then misses and gets its own fill; a later fetch of 0x08 hits.
6. Reset mid-fetch: assert `RST` while in `FETCH` with `iwait`=1.
   - Required: next cycle `iREN`=0, counters=0.
   - A previously valid address misses again after reset.
